// File: rtl/thread_select_stage_pkg.sv
// Shared core definitions used by the thread-select stage: thread count,
// scalar and thread index types, and the buffered fetch entry.
package thread_select_stage_pkg;

    localparam int THREADS_PER_CORE = 4;

    typedef logic [$clog2(THREADS_PER_CORE)-1:0] thread_idx_t;
    typedef logic [31:0]                         scalar_t;

    typedef struct packed {
        logic [31:0] instruction;
        scalar_t     pc;
    } ifetch_entry_t;

endpackage

// File: rtl/thread_select_stage_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
// A flush empties it and wins over a push in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign count     = r_count;
    assign data_out  = r_mem[r_rd_ptr];
    // Pushes into a full FIFO are dropped rather than overwriting the oldest entry.
    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && full));
`endif

endmodule

// File: rtl/thread_select_stage.sv
// Thread-select stage: one instruction FIFO per hardware thread and a
// round-robin pick of at most one enabled, non-empty thread per cycle.
module thread_select_stage
    import thread_select_stage_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ALMOST_FULL = FIFO_DEPTH - 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [THREADS_PER_CORE-1:0] cr_thread_enable,
    input  logic                        ifd_instruction_valid,
    input  thread_idx_t                 ifd_thread_idx,
    input  logic [31:0]                 ifd_instruction,
    input  scalar_t                     ifd_pc,
    output logic [THREADS_PER_CORE-1:0] ts_fetch_en,
    input  logic                        wb_rollback_en,
    input  thread_idx_t                 wb_rollback_thread_idx,
    input  logic                        id_stall,
    output logic                        ts_instruction_valid,
    output thread_idx_t                 ts_thread_idx,
    output logic [31:0]                 ts_instruction,
    output scalar_t                     ts_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifetch_entry_t               w_push_entry;
    ifetch_entry_t               w_head [THREADS_PER_CORE];
    logic [CW-1:0]               w_count [THREADS_PER_CORE];
    logic [THREADS_PER_CORE-1:0] w_empty;
    logic [THREADS_PER_CORE-1:0] w_rb_hit;
    logic [THREADS_PER_CORE-1:0] w_push;
    logic [THREADS_PER_CORE-1:0] w_pop;
    logic [THREADS_PER_CORE-1:0] w_eligible;
    logic                        w_found;
    logic                        w_issue;
    thread_idx_t                 w_sel_idx;
    thread_idx_t                 r_last_issued;

    assign w_push_entry = {ifd_instruction, ifd_pc};

    for (genvar t = 0; t < THREADS_PER_CORE; t++) begin : g_thread
        assign w_rb_hit[t]    = wb_rollback_en && (wb_rollback_thread_idx == thread_idx_t'(t));
        // A push racing a rollback of the same thread belongs to the flushed path.
        assign w_push[t]      = ifd_instruction_valid && (ifd_thread_idx == thread_idx_t'(t))
                                && !w_rb_hit[t];
        assign w_pop[t]       = w_issue && (w_sel_idx == thread_idx_t'(t));
        assign w_eligible[t]  = cr_thread_enable[t] && !w_empty[t] && !w_rb_hit[t];
        assign ts_fetch_en[t] = cr_thread_enable[t] && (w_count[t] < CW'(ALMOST_FULL));

        sync_fifo #(
            .WIDTH ($bits(ifetch_entry_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (w_push[t]),
            .pop      (w_pop[t]),
            .flush    (w_rb_hit[t]),
            .data_in  (w_push_entry),
            .data_out (w_head[t]),
            .empty    (w_empty[t]),
            .full     (),
            .count    (w_count[t])
        );
    end

    // Search begins one past the last issued thread; the final step wraps back to it.
    always_comb begin
        thread_idx_t cand;
        cand      = '0;
        w_found   = 1'b0;
        w_sel_idx = r_last_issued;
        for (int i = 1; i <= THREADS_PER_CORE; i++) begin
            cand = r_last_issued + thread_idx_t'(i);
            if (!w_found && w_eligible[cand]) begin
                w_found   = 1'b1;
                w_sel_idx = cand;
            end
        end
    end

    assign w_issue = w_found && !id_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_instruction_valid <= 1'b0;
            ts_thread_idx        <= '0;
            ts_instruction       <= '0;
            ts_pc                <= '0;
            r_last_issued        <= thread_idx_t'(THREADS_PER_CORE - 1);
        end else if (w_issue) begin
            ts_instruction_valid <= 1'b1;
            ts_thread_idx        <= w_sel_idx;
            ts_instruction       <= w_head[w_sel_idx].instruction;
            ts_pc                <= w_head[w_sel_idx].pc;
            r_last_issued        <= w_sel_idx;
        end else if (!id_stall || (wb_rollback_en && ts_thread_idx == wb_rollback_thread_idx)) begin
            ts_instruction_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_thread_select_stage.sv
// Directed bench for thread_select_stage: fairness, disable, stall,
// rollback, throttle and mid-run reset with hand-computed expectations.
module tb_thread_select_stage;
    import thread_select_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cr_thread_enable;
    logic        ifd_instruction_valid;
    thread_idx_t ifd_thread_idx;
    logic [31:0] ifd_instruction;
    scalar_t     ifd_pc;
    logic [3:0]  ts_fetch_en;
    logic        wb_rollback_en;
    thread_idx_t wb_rollback_thread_idx;
    logic        id_stall;
    logic        ts_instruction_valid;
    thread_idx_t ts_thread_idx;
    logic [31:0] ts_instruction;
    scalar_t     ts_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    thread_select_stage dut (
        .clk                    (clk),
        .reset                  (reset),
        .cr_thread_enable       (cr_thread_enable),
        .ifd_instruction_valid  (ifd_instruction_valid),
        .ifd_thread_idx         (ifd_thread_idx),
        .ifd_instruction        (ifd_instruction),
        .ifd_pc                 (ifd_pc),
        .ts_fetch_en            (ts_fetch_en),
        .wb_rollback_en         (wb_rollback_en),
        .wb_rollback_thread_idx (wb_rollback_thread_idx),
        .id_stall               (id_stall),
        .ts_instruction_valid   (ts_instruction_valid),
        .ts_thread_idx          (ts_thread_idx),
        .ts_instruction         (ts_instruction),
        .ts_pc                  (ts_pc)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic scalar_t f_pc(input int t, input int n);
        return 32'h1000 + 32'(t) * 32'h100 + 32'(n) * 32'd4;
    endfunction

    function automatic logic [31:0] f_ins(input int t, input int n);
        return 32'hA500_0000 | f_pc(t, n);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int t, input int n);
        ifd_instruction_valid = 1'b1;
        ifd_thread_idx        = thread_idx_t'(t);
        ifd_instruction       = f_ins(t, n);
        ifd_pc                = f_pc(t, n);
        step();
        ifd_instruction_valid = 1'b0;
    endtask

    task automatic expect_issue(input string tag, input int t, input int n);
        check_eq({tag, "_valid"}, 64'(ts_instruction_valid), 64'd1);
        check_eq({tag, "_thread"}, 64'(ts_thread_idx), 64'(t));
        check_eq({tag, "_pc"}, 64'(ts_pc), 64'(f_pc(t, n)));
        check_eq({tag, "_ins"}, 64'(ts_instruction), 64'(f_ins(t, n)));
    endtask

    task automatic check_count(input string tag, input int t, input int exp);
        check_eq(tag, 64'(dut.w_count[t]), 64'(exp));
    endtask

    task automatic do_reset();
        reset                  = 1'b1;
        cr_thread_enable       = 4'b0001;
        id_stall               = 1'b0;
        wb_rollback_en         = 1'b0;
        ifd_instruction_valid  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset                  = 1'b1;
        cr_thread_enable       = 4'b0001;
        ifd_instruction_valid  = 1'b0;
        ifd_thread_idx         = '0;
        ifd_instruction        = '0;
        ifd_pc                 = '0;
        wb_rollback_en         = 1'b0;
        wb_rollback_thread_idx = '0;
        id_stall               = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_valid", 64'(ts_instruction_valid), 64'd0);
        check_eq("rst_thread", 64'(ts_thread_idx), 64'd0);
        check_eq("rst_ins", 64'(ts_instruction), 64'd0);
        check_eq("rst_pc", 64'(ts_pc), 64'd0);
        check_eq("rst_fetch_en", 64'(ts_fetch_en), 64'b0001);
        for (int t = 0; t < 4; t++) check_count("rst_count", t, 0);

        // Fairness: 3 entries per thread, strict 0,1,2,3 rotation
        cr_thread_enable = 4'b1111;
        id_stall = 1'b1;
        for (int n = 0; n < 3; n++)
            for (int t = 0; t < 4; t++) push_one(t, n);
        check_eq("fair_fetch_en_full", 64'(ts_fetch_en), 64'b0000);
        check_eq("fair_stall_valid", 64'(ts_instruction_valid), 64'd0);
        id_stall = 1'b0;
        for (int n = 0; n < 3; n++)
            for (int t = 0; t < 4; t++) begin
                step();
                expect_issue("fair", t, n);
            end
        step();
        check_eq("fair_drain_valid", 64'(ts_instruction_valid), 64'd0);

        // Disabled threads 1 and 3 keep their entries
        id_stall = 1'b1;
        cr_thread_enable = 4'b0101;
        push_one(0, 0);
        push_one(2, 0);
        push_one(1, 0);
        push_one(3, 0);
        check_eq("dis_fetch_en", 64'(ts_fetch_en), 64'b0101);
        push_one(0, 1);
        push_one(2, 1);
        check_eq("dis_fetch_en_af", 64'(ts_fetch_en), 64'b0000);
        id_stall = 1'b0;
        step(); expect_issue("dis_a", 0, 0);
        step(); expect_issue("dis_b", 2, 0);
        step(); expect_issue("dis_c", 0, 1);
        step(); expect_issue("dis_d", 2, 1);
        step();
        check_eq("dis_drain_valid", 64'(ts_instruction_valid), 64'd0);
        check_count("dis_keep1", 1, 1);
        check_count("dis_keep3", 3, 1);

        // Stall for three cycles mid-stream
        do_reset();
        cr_thread_enable = 4'b1111;
        id_stall = 1'b1;
        for (int n = 0; n < 4; n++) push_one(0, n);
        id_stall = 1'b0;
        step(); expect_issue("stl_a", 0, 0);
        step(); expect_issue("stl_b", 0, 1);
        id_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            expect_issue("stl_hold", 0, 1);
            check_count("stl_count", 0, 2);
        end
        id_stall = 1'b0;
        step(); expect_issue("stl_c", 0, 2);
        step(); expect_issue("stl_d", 0, 3);
        step();
        check_eq("stl_drain_valid", 64'(ts_instruction_valid), 64'd0);

        // Rollback of thread 1 while it is on the output, with a racing push
        do_reset();
        cr_thread_enable = 4'b1111;
        id_stall = 1'b1;
        push_one(1, 0);
        push_one(1, 1);
        push_one(2, 0);
        id_stall = 1'b0;
        step(); expect_issue("rb_pre", 1, 0);
        id_stall               = 1'b1;
        wb_rollback_en         = 1'b1;
        wb_rollback_thread_idx = thread_idx_t'(1);
        ifd_instruction_valid  = 1'b1;
        ifd_thread_idx         = thread_idx_t'(1);
        ifd_instruction        = 32'h0000_0100;
        ifd_pc                 = 32'h0000_0100;
        step();
        wb_rollback_en        = 1'b0;
        ifd_instruction_valid = 1'b0;
        check_eq("rb_valid", 64'(ts_instruction_valid), 64'd0);
        check_count("rb_count1", 1, 0);
        id_stall = 1'b0;
        step(); expect_issue("rb_post", 2, 0);
        step();
        check_eq("rb_drain_valid", 64'(ts_instruction_valid), 64'd0);
        check_count("rb_count1_end", 1, 0);

        // Throttle at ALMOST_FULL = 2
        do_reset();
        id_stall = 1'b1;
        push_one(0, 0);
        check_eq("thr_en_1", 64'(ts_fetch_en[0]), 64'd1);
        push_one(0, 1);
        check_eq("thr_en_2", 64'(ts_fetch_en[0]), 64'd0);
        id_stall = 1'b0;
        step(); expect_issue("thr_pop", 0, 0);
        id_stall = 1'b1;
        check_eq("thr_en_after_pop", 64'(ts_fetch_en[0]), 64'd1);

        // Reset with every FIFO full and last_issued moved off its reset value
        do_reset();
        cr_thread_enable = 4'b1111;
        id_stall = 1'b1;
        push_one(0, 0);
        id_stall = 1'b0;
        step(); expect_issue("rs_pre", 0, 0);
        id_stall = 1'b1;
        for (int t = 0; t < 4; t++)
            for (int n = 0; n < 4; n++) push_one(t, n);
        for (int t = 0; t < 4; t++) check_count("rs_full", t, 4);
        reset = 1'b1;
        cr_thread_enable = 4'b0001;
        step();
        for (int t = 0; t < 4; t++) check_count("rs_count", t, 0);
        check_eq("rs_valid", 64'(ts_instruction_valid), 64'd0);
        check_eq("rs_pc", 64'(ts_pc), 64'd0);
        check_eq("rs_fetch_en", 64'(ts_fetch_en), 64'b0001);
        reset = 1'b0;
        cr_thread_enable = 4'b1111;
        push_one(1, 0);
        push_one(0, 0);
        id_stall = 1'b0;
        step(); expect_issue("rs_first", 0, 0);
        step(); expect_issue("rs_second", 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
